// File: rtl/demux_1x4_tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive demultiplexer.
package demux_1x4_tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Sticky per-frame error record; cleared at every frame start.
  typedef struct packed {
    logic par;
  } frame_err_t;

endpackage

// File: rtl/demux_slot_reg.sv
// One W-bit channel register with load enable and a registered one-cycle valid strobe.
module demux_slot_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         strobe_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= load & strobe_en;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/demux_1x4_tdm.sv
// TDM 1:4 receive demultiplexer: slot FSM, slot counter, sync/parity checks, frame strobes.
// Optional even-parity checking is enabled with `define DEMUX_1X4_TDM_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a sync beat to start a frame
// RUN   | frame in progress, s is the next slot expected
module demux_1x4_tdm
  import demux_1x4_tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        i,
  input  logic                i_valid,
  input  logic                sync,
`ifdef DEMUX_1X4_TDM_PARITY_EN
  input  logic                i_par,
  output logic                par_err,
`endif
  output logic [NCH*W-1:0]    F,
  output logic [NCH-1:0]      F_valid,
  output logic                frame_done,
  output logic                sync_err,
  output logic [SLOT_W-1:0]   s
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] s_nxt;
  logic [NCH-1:0]    load;
  logic              beat_err;
  logic              frame_done_nxt;
  logic              sync_err_nxt;
  frame_err_t        acc, acc_nxt;

`ifdef DEMUX_1X4_TDM_PARITY_EN
  // Even parity: i_par must equal the XOR of the data bits.
  assign beat_err = i_valid & ((^i) ^ i_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= beat_err & (|load);
  end
`else
  assign beat_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      acc        <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      s          <= s_nxt;
      acc        <= acc_nxt;
      frame_done <= frame_done_nxt;
      sync_err   <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    s_nxt          = s;
    load           = '0;
    acc_nxt        = acc;
    frame_done_nxt = 1'b0;
    sync_err_nxt   = 1'b0;
    if (i_valid) begin
      unique case (state)
        IDLE: begin
          if (sync) begin
            load[0]     = 1'b1;
            s_nxt       = SLOT_W'(1);
            acc_nxt.par = beat_err;
            state_nxt   = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Resync: abandon the partial frame, this beat becomes slot 0.
            sync_err_nxt = 1'b1;
            load[0]      = 1'b1;
            s_nxt        = SLOT_W'(1);
            acc_nxt.par  = beat_err;
          end else begin
            load[s]     = 1'b1;
            acc_nxt.par = acc.par | beat_err;
            if (s == SLOT_W'(NCH - 1)) begin
              s_nxt          = '0;
              state_nxt      = IDLE;
              frame_done_nxt = ~(acc.par | beat_err);
            end else begin
              s_nxt = s + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    demux_slot_reg #(.W(W)) u_slot_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[c]),
      .strobe_en (~beat_err),
      .d         (i),
      .q         (F[c*W +: W]),
      .vld       (F_valid[c])
    );
  end

endmodule
